sar_scan_ctrl: RTL and testbench

Multi-channel scan sequencer that drives the team's SAR conversion FSM. It steps an analog mux across the enabled channels and waits a settle time after each switch. It then fires one conversion per channel over the start/eoc handshake and delivers tagged results downstream. It sits between the register/control layer and the SAR core, and supports single-shot or continuous scanning with a conversion timeout watchdog.

---
 rtl/sar_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_sar_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: scans enabled mux channels, settles, runs one SAR conversion per channel and emits tagged results.
// Define SAR_SCAN_AVG_EN to average 2^AvgLog2 back-to-back conversions per channel.
module sar_scan_ctrl #(
  parameter int Width     = 8,
  parameter int NumCh     = 4,
  parameter int ChW       = 2,
  parameter int SettleCyc = 4,
  parameter int AvgLog2   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trig_i,
  input  logic             scan_en_i,
  input  logic [NumCh-1:0] ch_mask_i,
  output logic [ChW-1:0]   mux_sel_o,
  output logic             conv_start_o,
  input  logic             conv_eoc_i,
  input  logic [Width-1:0] conv_result_i,
  output logic [Width-1:0] data_o,
  output logic [ChW-1:0]   data_ch_o,
  output logic             data_valid_o,
  output logic             scan_done_o,
  output logic             busy_o,
  output logic             err_o
);
  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT_BUSY, WAIT_EOC, STORE, NEXT} state_t;
  localparam int CntMax = (SettleCyc > Width + 8) ? SettleCyc : Width + 8;
  localparam int CntW   = $clog2(CntMax);
  if (NumCh < 2 || NumCh > 16 || ChW != $clog2(NumCh) || SettleCyc < 1 || SettleCyc > 255 || AvgLog2 < 0) begin : g_bad_param
    $error("sar_scan_ctrl: parameter out of range");
  end
  state_t           state, state_d;
  logic [CntW-1:0]  cnt;
  logic [NumCh-1:0] mask_q, rem;
  logic [ChW-1:0]   ch;
  logic             go, last_ch, restart, start_scan, next_ch, settled, fire, got, timeout, last_samp;
  function automatic logic [ChW-1:0] lowest(input logic [NumCh-1:0] m);
    lowest = '0;
    for (int i = NumCh - 1; i >= 0; i--) if (m[i]) lowest = ChW'(i);
  endfunction
  always_comb begin
    rem = '0;
    for (int i = 0; i < NumCh; i++) rem[i] = mask_q[i] && (i > int'(ch));
  end
  assign go         = state == IDLE && (trig_i || scan_en_i) && |ch_mask_i;
  assign last_ch    = rem == '0;
  assign restart    = state == NEXT && last_ch && scan_en_i && |ch_mask_i;
  assign start_scan = go || restart;
  assign next_ch    = state == NEXT && !last_ch;
  assign settled    = cnt == CntW'(SettleCyc - 1);
  assign fire       = state == START && conv_eoc_i;
  assign got        = state == WAIT_EOC && conv_eoc_i;
  // cnt restarts on every state change, so it measures time spent in the current state
  assign timeout    = (state == WAIT_BUSY && conv_eoc_i && cnt == CntW'(3)) ||
                      (state == WAIT_EOC && !conv_eoc_i && cnt == CntW'(Width + 7));
  assign mux_sel_o  = ch;
  assign busy_o     = state != IDLE;
`ifdef SAR_SCAN_AVG_EN
  localparam int AccW = Width + AvgLog2;
  logic [AccW-1:0]  acc;
  logic [AvgLog2:0] samp;
  assign last_samp = samp == (AvgLog2 + 1)'((1 << AvgLog2) - 1);
`else
  logic [Width-1:0] res_q;
  assign last_samp = 1'b1;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = go ? SETTLE : IDLE;
      SETTLE:    state_d = settled ? START : SETTLE;
      START:     state_d = conv_eoc_i ? WAIT_BUSY : START;
      WAIT_BUSY: state_d = timeout ? IDLE : conv_eoc_i ? WAIT_BUSY : WAIT_EOC;
      WAIT_EOC:  state_d = timeout ? IDLE : !conv_eoc_i ? WAIT_EOC : last_samp ? STORE : START;
      STORE:     state_d = NEXT;
      NEXT:      state_d = (next_ch || restart) ? SETTLE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? '0 : cnt + CntW'(1);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q       <= '0;
      ch           <= '0;
      err_o        <= 1'b0;
      conv_start_o <= 1'b0;
      data_valid_o <= 1'b0;
      scan_done_o  <= 1'b0;
      data_o       <= '0;
      data_ch_o    <= '0;
`ifdef SAR_SCAN_AVG_EN
      acc          <= '0;
      samp         <= '0;
`else
      res_q        <= '0;
`endif
    end else begin
      conv_start_o <= fire;
      data_valid_o <= state == STORE;
      scan_done_o  <= state == NEXT && last_ch;
      if (start_scan) begin
        mask_q <= ch_mask_i;
        ch     <= lowest(ch_mask_i);
      end else if (next_ch) begin
        ch <= lowest(rem);
      end
      if (go) err_o <= 1'b0;
      else if (timeout) err_o <= 1'b1;
`ifdef SAR_SCAN_AVG_EN
      if (start_scan || next_ch) begin
        acc  <= '0;
        samp <= '0;
      end else if (got) begin
        acc  <= acc + AccW'(conv_result_i);
        samp <= samp + (AvgLog2 + 1)'(1);
      end
      if (state == STORE) begin
        data_o    <= Width'(acc >> AvgLog2);
        data_ch_o <= ch;
      end
`else
      if (got) res_q <= conv_result_i;
      if (state == STORE) begin
        data_o    <= res_q;
        data_ch_o <= ch;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: randomized scans against a behavioural SAR/mux environment and a scan-order reference model.
module tb_sar_scan_ctrl;
  localparam int Width = 8, NumCh = 4, ChW = 2, SettleCyc = 4, AvgLog2 = 2;
`ifdef SAR_SCAN_AVG_EN
  localparam int NS = 1 << AvgLog2, SH = AvgLog2;
`else
  localparam int NS = 1, SH = 0;
`endif
  logic clk = 0, rst = 1, trig = 0, scan_en = 0;
  logic [NumCh-1:0] mask = '0;
  logic [ChW-1:0]   mux_sel, data_ch;
  logic             conv_start, data_valid, scan_done, busy, err;
  logic             conv_eoc = 1'b1;
  logic [Width-1:0] conv_result = '0, data;
  always #5 clk = ~clk;
  sar_scan_ctrl #(.Width(Width), .NumCh(NumCh), .ChW(ChW), .SettleCyc(SettleCyc), .AvgLog2(AvgLog2)) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .scan_en_i(scan_en), .ch_mask_i(mask),
    .mux_sel_o(mux_sel), .conv_start_o(conv_start), .conv_eoc_i(conv_eoc), .conv_result_i(conv_result),
    .data_o(data), .data_ch_o(data_ch), .data_valid_o(data_valid), .scan_done_o(scan_done),
    .busy_o(busy), .err_o(err)
  );
  int n_vec = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // analog side: each channel presents base[ch]; successive samples on a channel add 0,1,2,...
  logic [Width-1:0] base [NumCh];
  logic [Width-1:0] sar_v;
  int  sar_mode = 0, sar_lat = 0, conv_idx = 0;
  bit  sar_busy = 0;
  initial forever begin
    @(negedge clk);
    if (conv_start && sar_mode != 1) begin
      sar_v = base[mux_sel] + Width'(conv_idx % NS);
      conv_idx++;
      sar_busy = 1;
      @(negedge clk);
      conv_eoc = 0;
      conv_result = ~sar_v;
      if (sar_mode == 2) begin
        while (sar_mode == 2) @(negedge clk);
      end else begin
        repeat (sar_lat > 0 ? sar_lat : int'($urandom_range(1, Width + 4))) @(negedge clk);
      end
      conv_result = sar_v;
      conv_eoc = 1;
      sar_busy = 0;
    end
  end
  int cyc = 0, done_cnt = 0, start_cnt = 0, start_cyc = 0, err_cyc = 0, since = 0;
  bit moved = 0, prev_err = 0;
  logic [ChW-1:0]   prev_mux = '0;
  logic [ChW-1:0]   got_ch[$];
  logic [Width-1:0] got_dat[$];
  initial forever begin
    @(negedge clk);
    cyc++;
    since++;
    if (mux_sel !== prev_mux) begin
      since = 0;
      moved = 1;
    end
    prev_mux = mux_sel;
    if (rst) moved = 0;
    if (conv_start) begin
      start_cnt++;
      start_cyc = cyc;
      if (moved) check("settle_to_start", since, SettleCyc + 1);
      moved = 0;
    end
    if (data_valid) begin
      got_ch.push_back(data_ch);
      got_dat.push_back(data);
    end
    if (scan_done) done_cnt++;
    if (err && !prev_err) err_cyc = cyc;
    prev_err = err;
  end
  function automatic logic [Width-1:0] exp_val(input int c);
    int s = 0;
    for (int k = 0; k < NS; k++) s += int'(base[c]) + k;
    return Width'(s >> SH);
  endfunction
  bit exp_err = 0;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_trig();
    @(negedge clk);
    trig = 1;
    @(negedge clk);
    trig = 0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask
  task automatic wait_sar();
    int n = 0;
    while (sar_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sar_idle", sar_busy, 0);
  endtask
  task automatic clear();
    got_ch.delete();
    got_dat.delete();
    done_cnt = 0;
    start_cnt = 0;
    conv_idx = 0;
  endtask
  task automatic check_results(input string tag, input logic [NumCh-1:0] m);
    int k = 0;
    check({tag, "_nres"}, got_ch.size(), $countones(m));
    for (int c = 0; c < NumCh; c++) begin
      if (m[c]) begin
        if (k < got_ch.size()) begin
          check({tag, "_ch"}, got_ch[k], c);
          check({tag, "_data"}, got_dat[k], exp_val(c));
        end
        k++;
      end
    end
  endtask
  task automatic scan_once(input string tag, input logic [NumCh-1:0] m, input bit keep, input bit poke);
    if (!keep) foreach (base[c]) base[c] = Width'($urandom_range(0, 250));
    clear();
    mask = m;
    pulse_trig();
    if (m != 0) begin
      exp_err = 0;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_err_clr"}, err, 0);
    end
    if (poke) begin
      mask = NumCh'($urandom);
      tick($urandom_range(1, 20));
      if (busy) begin
        trig = 1;
        @(negedge clk);
        trig = 0;
      end
    end
    wait_idle({tag, "_idle"});
    check_results(tag, m);
    check({tag, "_done"}, done_cnt, (m != 0) ? 1 : 0);
    check({tag, "_starts"}, start_cnt, $countones(m) * NS);
    check({tag, "_err"}, err, exp_err);
  endtask
  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_valid", data_valid, 0);
    check("rst_done", scan_done, 0);
    check("rst_start", conv_start, 0);
    check("rst_mux", mux_sel, 0);
    check("rst_data", {data_ch, data}, 0);
    tick(2);
    rst = 0;
    base[0] = 8'hA5; base[1] = 8'h11; base[2] = 8'h3C; base[3] = 8'h22;
    scan_once("single", 4'b0101, 1, 1);
    base[1] = 8'd10;
    scan_once("ch1", 4'b0010, 1, 0);
    begin : continuous
      int n = 0;
      foreach (base[c]) base[c] = Width'($urandom_range(0, 250));
      clear();
      mask = 4'b1000;
      scan_en = 1;
      while (got_ch.size() < 3 && n < 2000) begin
        tick(1);
        n++;
      end
      scan_en = 0;
      wait_idle("cont_idle");
      check("cont_nres_ge3", got_ch.size() >= 3, 1);
      check("cont_done", done_cnt, got_ch.size());
      check("cont_starts", start_cnt, got_ch.size() * NS);
      foreach (got_ch[i]) begin
        check("cont_ch", got_ch[i], 3);
        check("cont_data", got_dat[i], exp_val(3));
      end
    end
    sar_mode = 1;
    clear();
    mask = 4'b0110;
    pulse_trig();
    wait_idle("tobusy_idle");
    exp_err = 1;
    check("tobusy_err", err, 1);
    check("tobusy_lat", err_cyc - start_cyc, 4);
    check("tobusy_nres", got_ch.size(), 0);
    check("tobusy_done", done_cnt, 0);
    check("tobusy_starts", start_cnt, 1);
    tick(5);
    check("tobusy_hold", err, 1);
    sar_mode = 0;
    scan_once("after_to", 4'b0011, 0, 0);
    sar_mode = 2;
    clear();
    mask = 4'b0001;
    pulse_trig();
    wait_idle("toeoc_idle");
    exp_err = 1;
    check("toeoc_err", err, 1);
    check("toeoc_lat", err_cyc - start_cyc, 2 + Width + 8);
    check("toeoc_nres", got_ch.size(), 0);
    check("toeoc_done", done_cnt, 0);
    sar_mode = 0;
    wait_sar();
    scan_once("zero_mask", '0, 0, 0);
    begin : reset_mid
      int n = 0;
      sar_lat = 12;
      clear();
      mask = 4'b1010;
      pulse_trig();
      while (start_cnt == 0 && n < 100) begin
        tick(1);
        n++;
      end
      check("rstm_started", start_cnt, 1);
      tick(4);
      #2 rst = 1;
      #1;
      check("rstm_busy", busy, 0);
      check("rstm_err", err, 0);
      check("rstm_outs", {conv_start, data_valid, scan_done}, 0);
      check("rstm_mux", mux_sel, 0);
      check("rstm_data", {data_ch, data}, 0);
      exp_err = 0;
      tick(2);
      rst = 0;
      wait_sar();
      tick(10);
      check("rstm_nres", got_ch.size(), 0);
      check("rstm_done", done_cnt, 0);
      sar_lat = 0;
    end
    scan_once("post_rst", 4'b1010, 0, 0);
    repeat (20) scan_once("rnd", NumCh'($urandom), 0, 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end
endmodule
